chacha20_core: RTL and testbench
================================

# chacha20_core

Iterative ChaCha20 block function. It accepts the 512-bit initial state produced by `chacha20_state`, runs ROUNDS rounds (one column or diagonal round per cycle), and adds the original state to the result. It presents the 512-bit keystream block to the downstream cipher/XOR stage over a valid/ready handshake.

## Interface
Parameters:
- ROUNDS, 20, number of rounds; must be even (8, 12 or 20 are supported).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  state_in is valid.
- in_ready  out  1  core can accept a state; high only in IDLE.
- state_in  in  512  initial state; word i = state_in[511-32*i -: 32], so word0 = constant 0x61707865 at the MSBs.
- out_valid  out  1  keystream is valid; held until accepted.
- out_ready  in  1  downstream accepts keystream.
- keystream  out  512  output block, same word ordering as state_in.
- busy  out  1  high in ROUND and ADD.

## Operation
- FSM states: IDLE, ROUND, ADD, OUT.
- IDLE: in_ready=1. When in_valid is high, capture state_in into `orig` and `work`, clear rnd to 0, and go to ROUND.
- ROUND: each cycle, work <= round(work).
  - Even rnd: column round, QR(0,4,8,12), QR(1,5,9,13), QR(2,6,10,14), QR(3,7,11,15).
  - Odd rnd: diagonal round, QR(0,5,10,15), QR(1,6,11,12), QR(2,7,8,13), QR(3,4,9,14).
  - rnd increments each cycle. When rnd==ROUNDS-1, go to ADD.
- QR(a,b,c,d), all arithmetic mod 2^32, rotations left:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- ADD: keystream word i <= work[i] + orig[i] (mod 2^32, no carry between words). Go to OUT.
- OUT: out_valid=1, keystream stable. When out_ready is high, out_valid falls next cycle and the FSM returns to IDLE.
- No overlap: a new state is accepted only in IDLE, so there is at most one block in flight.
- in_valid outside IDLE is ignored. No input is dropped, because in_ready=0 outside IDLE.
- rnd counter is $clog2(ROUNDS) bits. It is never compared past ROUNDS-1.

## Timing
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, keystream=0, work=0, orig=0, rnd=0.
- Latency: accept edge E0. Rounds complete on edges E1..E_ROUNDS. Add completes on E_(ROUNDS+1). out_valid is high from E_(ROUNDS+1), i.e. 21 cycles after acceptance for ROUNDS=20.
- Throughput: one block per ROUNDS+3 cycles when out_ready is held high (accept + ROUNDS + ADD + OUT handshake).
- Reset asserted mid-operation: the block is aborted immediately, nothing is output, and all outputs take their reset values.
- out_ready high before OUT: no effect.
- keystream does not change while out_valid=1.

## Configuration
- CHACHA20_CORE_ZEROIZE_EN defined:
  - `work`, `orig` and `keystream` clear to 0 on the cycle after the output handshake.
  - keystream is forced to 0 whenever out_valid=0.
- Undefined:
  - registers retain their last values after the handshake.
  - keystream holds the last block until the next ADD.

## Structure
- Package `chacha20_pkg` contains:
  - constants C0..C3 (0x61707865, 0x3320646e, 0x79622d32, 0x6b206574).
  - `word_t` (logic [31:0]) and `state_t` (word_t [0:15]).
  - pack/unpack functions between the 512-bit vector and state_t.
  - the FSM enum.
  - `chacha20_state` also imports the constants from this package.
- Sub-module `chacha20_qr`: combinational quarter round, 4×32 in and 4×32 out, instantiated 4× with the index mapping muxed by rnd[0].

## Test plan
- QR unit, RFC 8439 §2.1.1: a=11111111, b=01020304, c=9b8d6f43, d=01234567 -> a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb.
- RFC 8439 §2.3.2 block: key bytes 00..1f, counter 1, nonce 000000090000004a00000000 -> keystream word0=e4e7f110, word1=15593bd1, word15=4e3c50a2. out_valid is asserted exactly 21 cycles after acceptance.
- All-zero state_in -> keystream all zero. Checks the ADD path and zero propagation.
- Backpressure: hold out_ready=0 for 10 cycles in OUT.
  - keystream is stable and out_valid stays high.
  - in_ready stays 0 and in_valid is ignored.
  - after out_ready rises: IDLE next cycle, in_ready=1.
- Reset asserted at round 7 -> out_valid=0, busy=0, in_ready=1 immediately. A following RFC vector produces the correct result.
- With CHACHA20_CORE_ZEROIZE_EN defined -> keystream reads 0 on the cycle after the handshake and while IDLE.

Source files
------------

// File: rtl/chacha20_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | chacha20_pkg: word/state types, sigma constants, FSM encoding and helpers
// | Revision: 1.0
// +---------------------------------------------------------------------------
package chacha20_pkg;

  typedef logic [31:0] word_t;
  typedef word_t state_t [0:15];

  localparam word_t C0 = 32'h61707865;
  localparam word_t C1 = 32'h3320646e;
  localparam word_t C2 = 32'h79622d32;
  localparam word_t C3 = 32'h6b206574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } fsm_e;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Word 0 lives at the MSBs of the flat vector.
  function automatic word_t unpack_word(input logic [511:0] v, input int i);
    return word_t'(v >> (32 * (15 - i)));
  endfunction

  function automatic logic [511:0] pack_state(input state_t s);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      v = {v[479:0], s[4'(i)]};
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chacha20_qr.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | chacha20_qr: combinational ChaCha quarter round on four 32-bit words
// | Revision: 1.0
// +---------------------------------------------------------------------------
module chacha20_qr
  import chacha20_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  assign a1 = a_i + b_i;
  assign d1 = rotl(d_i ^ a1, 16);
  assign c1 = c_i + d1;
  assign b1 = rotl(b_i ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_o = a2;
  assign b_o = b2;
  assign c_o = c2;
  assign d_o = d2;

endmodule
`default_nettype wire

// File: rtl/chacha20_core.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | chacha20_core: iterative ChaCha20 block function, one round per cycle.
// | Optional CHACHA20_CORE_ZEROIZE_EN clears state after each handshake.
// | Revision: 1.0
// +---------------------------------------------------------------------------
module chacha20_core
  import chacha20_pkg::*;
#(
  parameter int unsigned ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  localparam int unsigned      RW       = $clog2(ROUNDS);
  localparam logic [RW-1:0]    LAST_RND = RW'(ROUNDS - 1);

  fsm_e          fsm_q;
  logic [RW-1:0] rnd_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [511:0]  keystream_q;
  state_t        work_q;
  state_t        orig_q;

  state_t        work_d;
  state_t        sum_w;
  logic [511:0]  keystream_d;

  word_t         qa_o [4];
  word_t         qb_o [4];
  word_t         qc_o [4];
  word_t         qd_o [4];
  logic [3:0]    idx_b [4];
  logic [3:0]    idx_c [4];
  logic [3:0]    idx_d [4];

  // Lane g always owns word g as 'a'; rnd[0] selects column vs diagonal b/c/d.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_qr
      localparam logic [3:0] IA = 4'(g);
      localparam logic [3:0] CB = 4'(4 + g);
      localparam logic [3:0] CC = 4'(8 + g);
      localparam logic [3:0] CD = 4'(12 + g);
      localparam logic [3:0] DB = 4'(4 + ((g + 1) % 4));
      localparam logic [3:0] DC = 4'(8 + ((g + 2) % 4));
      localparam logic [3:0] DD = 4'(12 + ((g + 3) % 4));

      assign idx_b[g] = rnd_q[0] ? DB : CB;
      assign idx_c[g] = rnd_q[0] ? DC : CC;
      assign idx_d[g] = rnd_q[0] ? DD : CD;

      chacha20_qr u_qr (
        .a_i (work_q[IA]),
        .b_i (work_q[idx_b[g]]),
        .c_i (work_q[idx_c[g]]),
        .d_i (work_q[idx_d[g]]),
        .a_o (qa_o[g]),
        .b_o (qb_o[g]),
        .c_o (qc_o[g]),
        .d_o (qd_o[g])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      work_d[4'(i)] = work_q[4'(i)];
      sum_w[4'(i)]  = work_q[4'(i)] + orig_q[4'(i)];
    end
    for (int i = 0; i < 4; i++) begin
      work_d[4'(i)]         = qa_o[2'(i)];
      work_d[idx_b[2'(i)]]  = qb_o[2'(i)];
      work_d[idx_c[2'(i)]]  = qc_o[2'(i)];
      work_d[idx_d[2'(i)]]  = qd_o[2'(i)];
    end
    keystream_d = pack_state(sum_w);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= ST_IDLE;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      keystream_q <= '0;
      for (int i = 0; i < 16; i++) begin
        work_q[4'(i)] <= '0;
        orig_q[4'(i)] <= '0;
      end
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) begin
              work_q[4'(i)] <= unpack_word(state_in, i);
              orig_q[4'(i)] <= unpack_word(state_in, i);
            end
            rnd_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          for (int i = 0; i < 16; i++) begin
            work_q[4'(i)] <= work_d[4'(i)];
          end
          rnd_q <= rnd_q + 1'b1;
          if (rnd_q == LAST_RND) begin
            fsm_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          keystream_q <= keystream_d;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          fsm_q       <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= ST_IDLE;
`ifdef CHACHA20_CORE_ZEROIZE_EN
            keystream_q <= '0;
            for (int i = 0; i < 16; i++) begin
              work_q[4'(i)] <= '0;
              orig_q[4'(i)] <= '0;
            end
`endif
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

`ifdef CHACHA20_CORE_ZEROIZE_EN
  assign keystream = out_valid_q ? keystream_q : '0;
`else
  assign keystream = keystream_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chacha20_core.sv
`default_nettype none
// Directed bench for chacha20_core: RFC 8439 vectors, latency, backpressure, reset.
module tb_chacha20_core;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] state_in = '0;
  logic         in_ready, out_valid, busy;
  logic [511:0] keystream;

  logic [31:0]  qa, qb, qc, qd;
  logic [31:0]  qa_r, qb_r, qc_r, qd_r;

  int total = 0;
  int bad   = 0;

  localparam logic [511:0] RFC_IN = {
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  localparam logic [511:0] RFC_KS = {
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  always #5 clk = ~clk;

  chacha20_core #(.ROUNDS(20)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .keystream (keystream),
    .busy      (busy)
  );

  chacha20_qr u_qr (
    .a_i (qa), .b_i (qb), .c_i (qc), .d_i (qd),
    .a_o (qa_r), .b_o (qb_r), .c_o (qc_r), .d_o (qd_r)
  );

  // Presents one block from IDLE and waits for out_valid; lat=-1 on timeout.
  task automatic drive_block(input logic [511:0] vec, output int lat);
    in_valid = 1'b1;
    state_in = vec;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (keystream !== 512'd0) begin bad++; $display("FAIL rst_keystream got=%h exp=0", keystream); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_qr();
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    total++; if (qa_r !== 32'hea2a92f4) begin bad++; $display("FAIL qr_a got=%h exp=ea2a92f4", qa_r); end
    total++; if (qb_r !== 32'hcb1cf8ce) begin bad++; $display("FAIL qr_b got=%h exp=cb1cf8ce", qb_r); end
    total++; if (qc_r !== 32'h4581472e) begin bad++; $display("FAIL qr_c got=%h exp=4581472e", qc_r); end
    total++; if (qd_r !== 32'h5881c4bb) begin bad++; $display("FAIL qr_d got=%h exp=5881c4bb", qd_r); end
  endtask

  task automatic test_rfc_block();
    int lat;
    out_ready = 1'b1;  // held early: must not affect anything before OUT
    in_valid = 1'b1;
    state_in = RFC_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rfc_accept got in_ready=%b busy=%b exp 0/1", in_ready, busy);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 21) begin bad++; $display("FAIL rfc_latency got=%0d exp=21", lat); end
    total++; if (keystream[511 -: 32] !== 32'he4e7f110) begin bad++; $display("FAIL rfc_word0 got=%h exp=e4e7f110", keystream[511 -: 32]); end
    total++; if (keystream[479 -: 32] !== 32'h15593bd1) begin bad++; $display("FAIL rfc_word1 got=%h exp=15593bd1", keystream[479 -: 32]); end
    total++; if (keystream[31:0] !== 32'h4e3c50a2) begin bad++; $display("FAIL rfc_word15 got=%h exp=4e3c50a2", keystream[31:0]); end
    total++; if (keystream !== RFC_KS) begin bad++; $display("FAIL rfc_block got=%h exp=%h", keystream, RFC_KS); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rfc_busy_out got=%b exp=0", busy); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rfc_handshake got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_state();
    int lat;
    drive_block(512'd0, lat);
    total++; if (lat !== 21) begin bad++; $display("FAIL zero_latency got=%0d exp=21", lat); end
    total++; if (keystream !== 512'd0) begin bad++; $display("FAIL zero_keystream got=%h exp=0", keystream); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    drive_block(RFC_IN, lat);
    total++; if (lat !== 21) begin bad++; $display("FAIL bp_latency got=%0d exp=21", lat); end
    in_valid = 1'b1;
    state_in = 512'd0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || keystream !== RFC_KS) begin
        bad++; $display("FAIL bp_hold cycle=%0d got out_valid=%b in_ready=%b ks=%h exp 1/0 ks=%h", k, out_valid, in_ready, keystream, RFC_KS);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
`ifdef CHACHA20_CORE_ZEROIZE_EN
    total++; if (keystream !== 512'd0) begin bad++; $display("FAIL bp_zeroize got=%h exp=0", keystream); end
`else
    total++; if (keystream !== RFC_KS) begin bad++; $display("FAIL bp_retain got=%h exp=%h", keystream, RFC_KS); end
`endif
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_idle got in_ready=%b busy=%b exp 1/0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_round();
    int lat;
    in_valid = 1'b1;
    state_in = RFC_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_outputs got out_valid=%b busy=%b in_ready=%b exp 0/0/1", out_valid, busy, in_ready);
    end
    total++; if (keystream !== 512'd0) begin bad++; $display("FAIL midrst_keystream got=%h exp=0", keystream); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) break;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output got=%b exp=0", out_valid); end
    drive_block(RFC_IN, lat);
    total++; if (lat !== 21) begin bad++; $display("FAIL midrst_latency got=%0d exp=21", lat); end
    total++; if (keystream !== RFC_KS) begin bad++; $display("FAIL midrst_block got=%h exp=%h", keystream, RFC_KS); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int c, r1, r2;
    logic prev;
    logic [511:0] ks2;
    r1 = -1; r2 = -1; prev = 1'b0; ks2 = '0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    state_in = 512'd0;
    @(posedge clk); #1;
    state_in = RFC_IN;
    c = 0;
    while (c < 60) begin
      @(posedge clk); #1;
      c++;
      if (c == 23) in_valid = 1'b0;
      if (out_valid && !prev) begin
        if (r1 < 0) r1 = c;
        else begin r2 = c; ks2 = keystream; end
      end
      prev = out_valid;
    end
    out_ready = 1'b0;
    total++; if (r1 !== 21) begin bad++; $display("FAIL b2b_first got=%0d exp=21", r1); end
    total++; if (r2 !== 44) begin bad++; $display("FAIL b2b_second got=%0d exp=44", r2); end
    total++; if (ks2 !== RFC_KS) begin bad++; $display("FAIL b2b_block got=%h exp=%h", ks2, RFC_KS); end
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    qa = '0; qb = '0; qc = '0; qd = '0;
    test_reset();
    test_qr();
    test_rfc_block();
    test_zero_state();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
